rom_pwm_player: RTL
===================

Name: rom_pwm_player

Overview:
- Initiator-side reader for the PWM ROM.
- Drives the ROM's ce/read_en/address and latches the returned samples as successive duty cycles.
- Emits a PWM waveform: each sample lasts a programmable number of PWM periods, and the sequence loops over the address window [start_addr, end_addr].
- Sits between the ROM and the PWM output pin.

Parameters:
- DATA_WIDTH, 8: ROM word / duty width; PWM period = 2**DATA_WIDTH-1 cycles.
- ADDRESS_WIDTH, 8: ROM address width.
- STEP_WIDTH, 16: width of step_div.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- enable  in  1  run request; level-sensitive.
- start_addr  in  ADDRESS_WIDTH  first sample address, latched in PRIME.
- end_addr  in  ADDRESS_WIDTH  last sample address, read live.
- step_div  in  STEP_WIDTH  PWM periods per sample, read live; 0 treated as 1.
- rom_ce  out  1  ROM chip enable.
- rom_read_en  out  1  ROM read enable.
- rom_address  out  ADDRESS_WIDTH  = addr_reg.
- rom_data  in  DATA_WIDTH  ROM data (combinational from address).
- pwm_out  out  1  PWM output.
- duty  out  DATA_WIDTH  duty currently playing.
- period_done  out  1  one-cycle pulse per completed PWM period.
- done  out  1  sequence finished; only driven with PWM_ONESHOT_EN, tied 0 otherwise.

Behaviour:
- Interface decided: one clock clk; reset rst_n synchronous, active-low; overrides everything.
- Reset values: state IDLE, addr_reg 0, duty 0, shadow 0, pwm_cnt 0, rep_cnt 0, running 0. All outputs 0.
- States:
  - IDLE: outputs as reset. enable=1 -> PRIME.
  - PRIME (1 cycle): rom_ce=rom_read_en=1, rom_address=start_addr. At the edge: duty<=rom_data, addr_reg<=next(start_addr) -> FETCH.
  - FETCH (1 cycle): rom_ce=rom_read_en=1, rom_address=addr_reg. At the edge: shadow<=rom_data -> RUN; running<=1.
  - RUN: ROM strobes 0.
- next(a) = (a==end_addr) ? start_addr : a+1, modulo 2**ADDRESS_WIDTH. start_addr==end_addr gives a constant sample.
- PWM counter:
  - pwm_cnt counts 0..2**DATA_WIDTH-2 while running=1, in both RUN and FETCH.
  - pwm_out = running && (pwm_cnt < duty). duty=0 gives constant low; duty=all-ones gives constant high.
- Period boundary (pwm_cnt==2**DATA_WIDTH-2 edge):
  - pwm_cnt<=0, period_done<=1 for exactly one cycle.
  - If rep_cnt==max(step_div,1)-1: rep_cnt<=0, duty<=shadow, addr_reg<=next(addr_reg), state<=FETCH (prefetch while the PWM keeps running).
  - Else rep_cnt++.
- Duty changes only at period boundaries; the PWM never glitches mid-period.
- Latency: enable sampled high at edge 0 -> PRIME in cycle 1, FETCH in cycle 2, RUN with pwm_cnt=0 in cycle 3.
- enable low in any state -> IDLE at the next edge; all outputs return to reset values (mid-period abort). Re-enable restarts from start_addr.
- Changing end_addr or step_div mid-run takes effect at the next boundary decision.
- Prefetch is always complete before the next boundary, since the period is at least 1 cycle longer than the 1-cycle FETCH (DATA_WIDTH>=2).

Optional Feature:
- PWM_ONESHOT_EN defined:
  - Flag duty_last is set when duty is loaded from the sample at end_addr.
  - At an advance boundary with duty_last=1, go to state DONE instead of loading: running=0, pwm_out=0, done=1, ROM strobes 0.
  - Hold DONE until enable=0 -> IDLE.
- Undefined: sequence loops forever; done tied 0; no DONE state.

Decomposition:
- Package rom_pwm_pkg:
  - state enum (IDLE, PRIME, FETCH, RUN, DONE);
  - function pwm_period(DATA_WIDTH) returning 2**DATA_WIDTH-1;
  - constant STEP_MIN=1.
- One sub-module pwm_core:
  - pwm_cnt, compare, period_done, and duty register with load strobe;
  - instantiated once; the top holds the FSM, address logic and rep_cnt.

Test Plan:
Setup for all scenarios: 4-entry ROM {00,80,FF,40}, start=0, end=3, DATA_WIDTH=8.
1. rst_n low 2 cycles with enable=1 -> pwm_out, rom_ce, rom_read_en, duty, period_done all 0; rom_address 0.
2. enable rises at edge 0 -> rom_ce=1 in cycles 1-2 with address 0 then 1; pwm_cnt=0 in cycle 3; first period (255 cycles) pwm_out stays 0.
3. step_div=1 -> high-time per period 0, 128, 255, 64, 0 (wraps end->start); period_done pulses every 255 cycles; address sequence 2,3,0,1.
4. step_div=3 -> each duty held exactly 3 periods; step_div=0 -> identical to step_div=1.
5. Drop enable at pwm_cnt=100 of a duty-80 period -> next cycle pwm_out=0, state IDLE; re-enable -> restarts at address 0 after 3-cycle latency.
6. PWM_ONESHOT_EN, step_div=1 -> four periods (00,80,FF,40) then done=1, pwm_out=0 held; enable low -> done=0.

Source files
------------

// File: rtl/rom_pwm_pkg.sv
// Shared types and helpers for the ROM-driven PWM player.
// Exports: state_e, STEP_MIN, pwm_period().
package rom_pwm_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PRIME = 3'd1,
    FETCH = 3'd2,
    RUN   = 3'd3,
    DONE  = 3'd4
  } state_e;

  // Smallest number of PWM periods a sample can last.
  localparam int unsigned STEP_MIN = 1;

  // Cycles per PWM period for a given duty width.
  function automatic int unsigned pwm_period(
    input int unsigned dw
  );
    return (32'd1 << dw) - 32'd1;
  endfunction

endpackage

// File: rtl/rom_pwm_player_core.sv
// PWM engine: period counter, duty compare, period pulse, duty register.
// Ports: clk, rst_n, clr, run, load, load_val -> pwm_out, duty,
//        period_done, wrap (last count of the period, combinational).
module pwm_core
  import rom_pwm_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  run,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_val,
  output logic                  pwm_out,
  output logic [DATA_WIDTH-1:0] duty,
  output logic                  period_done,
  output logic                  wrap
);

  localparam logic [DATA_WIDTH-1:0] CNT_MAX =
    DATA_WIDTH'(pwm_period(DATA_WIDTH) - 32'd1);

  logic [DATA_WIDTH-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] duty_q, duty_d;
  logic                  pd_q, pd_d;

  assign wrap = run && (cnt_q == CNT_MAX);

  always_comb begin
    cnt_d  = cnt_q;
    duty_d = duty_q;
    pd_d   = 1'b0;
    if (clr) begin
      cnt_d  = '0;
      duty_d = '0;
    end else begin
      if (run) begin
        cnt_d = wrap ? '0 : cnt_q + 1'b1;
      end
      pd_d = wrap;
      if (load) begin
        duty_d = load_val;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      duty_q <= '0;
      pd_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      duty_q <= duty_d;
      pd_q   <= pd_d;
    end
  end

  // cnt never exceeds CNT_MAX, so all-ones duty keeps the output high.
  assign pwm_out     = run && (cnt_q < duty_q);
  assign duty        = duty_q;
  assign period_done = pd_q;

endmodule

// File: rtl/rom_pwm_player.sv
// Reads duty samples from a ROM window and plays them as PWM periods.
// Ports: clk, rst_n, enable, start_addr, end_addr, step_div, rom_* ,
//        pwm_out, duty, period_done, done. Option: PWM_ONESHOT_EN.
module rom_pwm_player
  import rom_pwm_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 8,
  parameter int STEP_WIDTH    = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic [ADDRESS_WIDTH-1:0] start_addr,
  input  logic [ADDRESS_WIDTH-1:0] end_addr,
  input  logic [STEP_WIDTH-1:0]    step_div,
  output logic                     rom_ce,
  output logic                     rom_read_en,
  output logic [ADDRESS_WIDTH-1:0] rom_address,
  input  logic [DATA_WIDTH-1:0]    rom_data,
  output logic                     pwm_out,
  output logic [DATA_WIDTH-1:0]    duty,
  output logic                     period_done,
  output logic                     done
);

  state_e                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [ADDRESS_WIDTH-1:0] start_q, start_d;
  logic [DATA_WIDTH-1:0]    shadow_q, shadow_d;
  logic [STEP_WIDTH-1:0]    rep_q, rep_d;
  logic                     running_q, running_d;
`ifdef PWM_ONESHOT_EN
  logic                     last_q, last_d;
`endif

  logic                  core_clr;
  logic                  core_load;
  logic [DATA_WIDTH-1:0] core_val;
  logic                  wrap;
  logic [STEP_WIDTH-1:0] step_eff;
  logic                  advance;

  function automatic logic [ADDRESS_WIDTH-1:0] next_addr(
    input logic [ADDRESS_WIDTH-1:0] a,
    input logic [ADDRESS_WIDTH-1:0] base,
    input logic [ADDRESS_WIDTH-1:0] last
  );
    return (a == last) ? base : a + 1'b1;
  endfunction

  assign step_eff = (step_div == '0) ?
                    STEP_WIDTH'(STEP_MIN) : step_div;
  // >= keeps a shrinking step_div from stretching a sample.
  assign advance  = wrap && (rep_q >= step_eff - 1'b1);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    start_d   = start_q;
    shadow_d  = shadow_q;
    rep_d     = rep_q;
    running_d = running_q;
    core_clr  = 1'b0;
    core_load = 1'b0;
    core_val  = shadow_q;
`ifdef PWM_ONESHOT_EN
    last_d    = last_q;
`endif
    if (!enable) begin
      state_d   = IDLE;
      addr_d    = '0;
      start_d   = '0;
      shadow_d  = '0;
      rep_d     = '0;
      running_d = 1'b0;
      core_clr  = 1'b1;
`ifdef PWM_ONESHOT_EN
      last_d    = 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = PRIME;
        end
        PRIME: begin
          core_load = 1'b1;
          core_val  = rom_data;
          start_d   = start_addr;
          addr_d    = next_addr(start_addr, start_addr, end_addr);
`ifdef PWM_ONESHOT_EN
          last_d    = (start_addr == end_addr);
`endif
          state_d   = FETCH;
        end
        FETCH: begin
          shadow_d  = rom_data;
          running_d = 1'b1;
          state_d   = RUN;
        end
        RUN: begin
          if (advance) begin
            rep_d = '0;
`ifdef PWM_ONESHOT_EN
            if (last_q) begin
              running_d = 1'b0;
              state_d   = DONE;
            end else begin
              core_load = 1'b1;
              // shadow holds the word fetched from addr_q
              last_d    = (addr_q == end_addr);
              addr_d    = next_addr(addr_q, start_q, end_addr);
              state_d   = FETCH;
            end
`else
            core_load = 1'b1;
            addr_d    = next_addr(addr_q, start_q, end_addr);
            state_d   = FETCH;
`endif
          end else if (wrap) begin
            rep_d = rep_q + 1'b1;
          end
        end
`ifdef PWM_ONESHOT_EN
        DONE: begin
          state_d = DONE;
        end
`endif
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      start_q   <= '0;
      shadow_q  <= '0;
      rep_q     <= '0;
      running_q <= 1'b0;
`ifdef PWM_ONESHOT_EN
      last_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      start_q   <= start_d;
      shadow_q  <= shadow_d;
      rep_q     <= rep_d;
      running_q <= running_d;
`ifdef PWM_ONESHOT_EN
      last_q    <= last_d;
`endif
    end
  end

  pwm_core #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_core (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (core_clr),
    .run         (running_q),
    .load        (core_load),
    .load_val    (core_val),
    .pwm_out     (pwm_out),
    .duty        (duty),
    .period_done (period_done),
    .wrap        (wrap)
  );

  // PRIME addresses start_addr directly; addr_q is not yet loaded.
  assign rom_ce      = (state_q == PRIME) || (state_q == FETCH);
  assign rom_read_en = rom_ce;
  assign rom_address = (state_q == PRIME) ? start_addr : addr_q;

`ifdef PWM_ONESHOT_EN
  assign done = (state_q == DONE);
`else
  assign done = 1'b0;
`endif

endmodule
